// File: rtl/fmul_pkg.sv
// fmul_pkg: shared flag indices, operand classes and format helpers for fmul_pipe
package fmul_pkg;
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} cls_e;
  function automatic int bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(int exp_w, int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fmul_if.sv
// fmul_if: operand/result valid-ready bundle between a producer/consumer and fmul_pipe
interface fmul_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic [W-1:0] a_i, b_i, c_o;
  logic [TAG_W-1:0] tag_i, tag_o;
  logic [3:0] flags_o;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  modport slave (
    input  a_i, b_i, tag_i, in_valid_i, out_ready_i,
    output in_ready_o, c_o, flags_o, tag_o, out_valid_o
  );
  modport master (
    output a_i, b_i, tag_i, in_valid_i, out_ready_i,
    input  in_ready_o, c_o, flags_o, tag_o, out_valid_o
  );
endinterface

// File: rtl/fmul_round.sv
// fmul_round: normalise, round-to-nearest-even, range check, pack and flag the raw product
module fmul_round
  import fmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic                     nan_i,
  input  logic                     nv_i,
  input  logic                     inf_i,
  input  logic                     zero_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  output logic [EXP_W+MAN_W:0]     c_o,
  output logic [3:0]               flags_o
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [W-1:0] QN = W'(qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  logic [PW-1:0] norm;
  logic [MAN_W:0] mant;
  logic [MAN_W+1:0] rnd;
  logic g, r, st, inx, inc;
  logic signed [EW-1:0] e;
  always_comb begin
    norm = prod_i[PW-1] ? prod_i : prod_i << 1;
    mant = norm[PW-1 -: MAN_W+1];
    g = norm[PW-MAN_W-2];
    r = norm[PW-MAN_W-3];
    st = |norm[PW-MAN_W-4:0];
    inx = g | r | st;
    inc = g & (r | st | mant[0]);
    rnd = {1'b0, mant} + (MAN_W+2)'(inc);
    // a rounding carry leaves the stored field all-zero, so only the exponent moves
    e = exp_i + $signed(EW'(prod_i[PW-1])) + $signed(EW'(rnd[MAN_W+1]));
    flags_o = '0;
    c_o = {sign_i, e[EXP_W-1:0], rnd[MAN_W-1:0]};
    if (nan_i) begin
      c_o = QN;
      flags_o[FLAG_NV] = nv_i;
    end else if (inf_i) begin
      c_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_i) begin
      c_o = {sign_i, {(W-1){1'b0}}};
    end else if (e >= EMAX) begin
      c_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLAG_OF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else if (e <= 0) begin
      c_o = {sign_i, {(W-1){1'b0}}};
      flags_o[FLAG_UF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else begin
      flags_o[FLAG_NX] = inx;
    end
  end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage floating-point multiplier with valid/ready flow control and tags
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic   clk_i,
  input logic   rst_i,
  fmul_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));
  logic adv;
  logic s1_v_q, s1_s_q, s1_s_d;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, tag_q;
  cls_e s1_ca_q, s1_cb_q, s1_ca_d, s1_cb_d;
  logic signed [EW-1:0] s1_e_q, s1_e_d, s2_e_q;
  logic [MW-1:0] s1_ma_q, s1_mb_q;
  logic s2_v_q, s2_s_q, s2_nan_q, s2_nv_q, s2_inf_q, s2_zero_q;
  logic s2_nan_d, s2_nv_d, s2_inf_d, s2_zero_d;
  logic [2*MW-1:0] s2_p_q, s2_p_d;
  logic [W-1:0] c_q, c_d;
  logic [3:0] flags_q, flags_d;
  logic ov_q;
  // subnormals classify as ZERO, which is how they get flushed
  function automatic cls_e classify(logic [W-1:0] x);
    return ~|x[W-2 -: EXP_W] ? ZERO : ~&x[W-2 -: EXP_W] ? NORM :
           ~|x[MAN_W-1:0] ? INF : x[MAN_W-1] ? QNAN : SNAN;
  endfunction
  assign adv = !ov_q || bus.out_ready_i;
  always_comb begin
    s1_ca_d = classify(bus.a_i);
    s1_cb_d = classify(bus.b_i);
    s1_s_d = bus.a_i[W-1] ^ bus.b_i[W-1];
    s1_e_d = $signed(EW'(bus.a_i[W-2 -: EXP_W])) + $signed(EW'(bus.b_i[W-2 -: EXP_W])) - BIAS_S;
  end
  always_comb begin
    s2_inf_d = s1_ca_q == INF || s1_cb_q == INF;
    s2_zero_d = s1_ca_q == ZERO || s1_cb_q == ZERO;
    s2_nv_d = s1_ca_q == SNAN || s1_cb_q == SNAN || (s2_inf_d && s2_zero_d);
    s2_nan_d = s2_nv_d || s1_ca_q == QNAN || s1_cb_q == QNAN;
    s2_p_d = (2*MW)'(s1_ma_q) * (2*MW)'(s1_mb_q);
  end
  fmul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign_i(s2_s_q), .nan_i(s2_nan_q), .nv_i(s2_nv_q), .inf_i(s2_inf_q), .zero_i(s2_zero_q),
    .exp_i(s2_e_q), .prod_i(s2_p_q), .c_o(c_d), .flags_o(flags_d)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_q <= 1'b0;
      s1_s_q <= 1'b0;
      s1_tag_q <= '0;
      s1_ca_q <= ZERO;
      s1_cb_q <= ZERO;
      s1_e_q <= '0;
      s1_ma_q <= '0;
      s1_mb_q <= '0;
      s2_v_q <= 1'b0;
      s2_s_q <= 1'b0;
      s2_tag_q <= '0;
      s2_nan_q <= 1'b0;
      s2_nv_q <= 1'b0;
      s2_inf_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_e_q <= '0;
      s2_p_q <= '0;
      ov_q <= 1'b0;
      c_q <= '0;
      flags_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      s1_v_q <= bus.in_valid_i;
      s1_s_q <= s1_s_d;
      s1_tag_q <= bus.tag_i;
      s1_ca_q <= s1_ca_d;
      s1_cb_q <= s1_cb_d;
      s1_e_q <= s1_e_d;
      s1_ma_q <= {1'b1, bus.a_i[MAN_W-1:0]};
      s1_mb_q <= {1'b1, bus.b_i[MAN_W-1:0]};
      s2_v_q <= s1_v_q;
      s2_s_q <= s1_s_q;
      s2_tag_q <= s1_tag_q;
      s2_nan_q <= s2_nan_d;
      s2_nv_q <= s2_nv_d;
      s2_inf_q <= s2_inf_d;
      s2_zero_q <= s2_zero_d;
      s2_e_q <= s1_e_q;
      s2_p_q <= s2_p_d;
      ov_q <= s2_v_q;
      c_q <= c_d;
      flags_q <= flags_d;
      tag_q <= s2_tag_q;
    end
  end
  assign bus.in_ready_o = adv;
  assign bus.out_valid_o = ov_q;
  assign bus.c_o = c_q;
  assign bus.flags_o = flags_q;
  assign bus.tag_o = tag_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed scoreboard bench for fmul_pipe (single precision)
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fmul_if bus();
  fmul_pipe dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  typedef struct packed {logic [31:0] c; logic [3:0] f; logic [3:0] t;} exp_t;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [31:0] c; logic [3:0] f;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, sent = 0, got = 0;
  vec_t vecs [14] = '{
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
    '{32'hBF800000, 32'h7F800000, 32'hFF800000, 4'b0000},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
    '{32'h00400000, 32'h00400000, 32'h00000000, 4'b0000},
    '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000},
    '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
    '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000},
    '{32'h80400000, 32'h3F800000, 32'h80000000, 4'b0000},
    '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000}
  };

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // results leaving the DUT are taken on the coming edge; compare against scoreboard order
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      got++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result observed_tag=%h expected=none", bus.tag_o);
      end else begin
        mon_e = sb.pop_front();
        check("result_c", bus.c_o, mon_e.c);
        check("result_flags", 32'(bus.flags_o), 32'(mon_e.f));
        check("result_tag", 32'(bus.tag_o), 32'(mon_e.t));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                      input logic [31:0] c, input logic [3:0] f);
    int n = 0;
    bus.a_i = a;
    bus.b_i = b;
    bus.tag_i = t;
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && n < 50) begin
      step();
      n++;
    end
    check("accept_wait", 32'(n < 50), 32'd1);
    sb.push_back('{c, f, t});
    sent++;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  // edges from the accepting edge to the edge that transfers the result
  task automatic latency(output int lat);
    int e = 0;
    while (!bus.out_valid_o && e < 20) begin
      step();
      e++;
    end
    lat = e + 1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] sb_b [4] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000};
    logic [31:0] sb_c [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000};
    bus.a_i = '0;
    bus.b_i = '0;
    bus.tag_i = '0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_c", bus.c_o, 32'd0);
    check("rst_flags", 32'(bus.flags_o), 32'd0);
    check("rst_tag", 32'(bus.tag_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    send(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000);
    latency(lat);
    check("latency_basic", 32'(lat), 32'd3);
    step();
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, 4'(i), vecs[i].c, vecs[i].f);
    drain();
    for (int i = 0; i < 4; i++) send(32'h40000000, sb_b[i], 4'(i), sb_c[i], 4'b0000);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
      check("stall_valid", 32'(bus.out_valid_o), 32'd1);
      check("stall_c", bus.c_o, sb[0].c);
      check("stall_tag", 32'(bus.tag_o), 32'(sb[0].t));
      step();
    end
    bus.out_ready_i = 1'b1;
    drain();
    check("stall_count", 32'(got), 32'(sent));
    send(32'h40000000, 32'h40000000, 4'd9, 32'h40800000, 4'b0000);
    send(32'h40400000, 32'h40000000, 4'd10, 32'h40C00000, 4'b0000);
    rst = 1'b1;
    #1;
    check("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("flush_c", bus.c_o, 32'd0);
    check("flush_tag", 32'(bus.tag_o), 32'd0);
    sb.delete();
    sent -= 2;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush_quiet", 32'(bus.out_valid_o), 32'd0);
    end
    send(32'h3FC00000, 32'h40000000, 4'd7, 32'h40400000, 4'b0000);
    latency(lat);
    check("latency_after_rst", 32'(lat), 32'd3);
    step();
    drain();
    check("total_count", 32'(got), 32'(sent));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 Parameter TAG_W, default 4, width of a user tag carried alongside each operation.
REQ-004 clk_i  input  1  sole clock, rising-edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 a_i  input  W  operand A, IEEE-754 layout {sign, exp, man}.
REQ-007 b_i  input  W  operand B, same layout.
REQ-008 tag_i  input  TAG_W  tag for the operation offered this cycle.
REQ-009 in_valid_i  input  1  operands and tag valid.
REQ-010 in_ready_o  output  1  block accepts an operation this cycle.
REQ-011 c_o  output  W  product.
REQ-012 flags_o  output  4  exception flags {NV, OF, UF, NX} (bit 3 to bit 0).
REQ-013 tag_o  output  TAG_W  tag of the operation on c_o.
REQ-014 out_valid_o  output  1  c_o, flags_o and tag_o valid.
REQ-015 out_ready_i  input  1  consumer takes the result this cycle.

Function
REQ-016 Transfer occurs on a clock edge where valid and ready are both high, on each side independently.
REQ-017 Three register stages: S1 unpack/classify/exponent sum; S2 mantissa product; S3 normalise/round/pack, driving the outputs.
REQ-018 Latency: result for an operation accepted at edge N is presented at edge N+3 when there is no stall; throughput is one operation per cycle.
REQ-019 Advance = !out_valid_o || out_ready_i; in_ready_o = advance (combinational from out_ready_i); when advance is low, all stage registers hold.
REQ-020 While out_valid_o=1 and out_ready_i=0, c_o, flags_o and tag_o are held stable; results leave strictly in acceptance order.
REQ-021 Bubbles propagate: a stage with no valid operation advances as empty; out_valid_o falls when S3 holds no operation and advance occurs.
REQ-022 Sign of every result, including zero and infinity, = sign_a XOR sign_b; the exception is NaN (REQ-026).
REQ-023 Subnormal inputs are flushed to signed zero before use; NX is not raised for flushing.
REQ-024 Biased exponent = ea + eb - BIAS, where BIAS = 2^(EXP_W-1)-1, computed signed in EXP_W+2 bits; mantissa product is (MAN_W+1)x(MAN_W+1) unsigned.
REQ-025 Rounding is round-to-nearest-even using guard, round and sticky bits; mantissa carry-out from rounding increments the exponent.
REQ-026 NaN input, or infinity x zero, produces the canonical quiet NaN {0, all-ones exp, MSB of man =1, rest 0}; invalid cases set NV; a signalling-NaN input also sets NV.
REQ-027 Infinity x finite non-zero produces signed infinity with no flags set.
REQ-028 Rounded exponent >= 2^EXP_W-1 produces signed infinity with OF=1 and NX=1.
REQ-029 Rounded exponent <= 0 produces signed zero: UF=1, and NX=1 if the exact product is non-zero.
REQ-030 NX=1 whenever any discarded product bit is non-zero.

Reset
REQ-031 rst_i=1 immediately clears all stage valid bits; out_valid_o=0, c_o=0, flags_o=0 and tag_o=0; in_ready_o=1.
REQ-032 Operations in flight when reset is asserted are discarded and are never emitted after reset is released.
REQ-033 The first accept after release completes in 3 cycles under REQ-018.

Structure
REQ-034 Package fmul_pkg holds: flag bit indices; the operand class enum {ZERO, NORM, INF, QNAN, SNAN}; and functions returning BIAS and the canonical qNaN for a given EXP_W/MAN_W.
REQ-035 A combinational sub-module fmul_round (normalise, RNE round, overflow/underflow detection, pack, flag generation) is instantiated in S3.

Verification
REQ-036 A=0x3FC00000 (1.5), B=0x40000000 (2.0), tag 5 -> c_o=0x40400000, flags 0, tag_o=5, exactly 3 cycles after accept.
REQ-037 A=0x7F800000 (+inf), B=0x00000000 -> c_o=0x7FC00000, NV=1; A=0xBF800000, B=0x7F800000 -> 0xFF800000, flags 0.
REQ-038 A=0x7F000000, B=0x40000000 -> 0x7F800000, OF=1, NX=1; A=0x00800000, B=0x3F000000 -> 0x00000000, UF=1, NX=1.
REQ-039 A=B=0x3F800001 -> 0x3F800002, NX=1; A=B=0x00400000 (subnormal) -> 0x00000000, flags 0.
REQ-040 Four back-to-back ops, tags 0-3, with out_ready_i low for 3 cycles after the first result -> in_ready_o low during the stall, c_o stable, results in tag order 0-3, none lost or duplicated.
REQ-041 Accept 2 ops, then assert rst_i for 1 cycle before either emerges -> out_valid_o=0 immediately; no result emerges afterwards; a new op then completes with 3-cycle latency.
